// File: rtl/adc_spi_if.sv
// Conversion request, SPI pins and sample result shared between the ADC reader and its peers.
interface adc_spi_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start_conversion;
    logic                  miso;
    logic                  cs_n;
    logic                  sck;
    logic [DATA_WIDTH-1:0] adc_data;
    logic                  data_ready;
    logic                  busy;

    // master: the SPI reader itself; slave: the ADC / requester side
    modport master (
        input  start_conversion,
        input  miso,
        output cs_n,
        output sck,
        output adc_data,
        output data_ready,
        output busy
    );

    modport slave (
        output start_conversion,
        output miso,
        input  cs_n,
        input  sck,
        input  adc_data,
        input  data_ready,
        input  busy
    );
endinterface

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master: one MSB-first ADC read per accepted request, result on a parallel word
// with a one-cycle data_ready strobe.
module adc_spi_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SCK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned CS_IDLE    = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    adc_spi_if.master bus
);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned PH_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PH_MAX = (PH_SH > CS_IDLE) ? PH_SH : CS_IDLE;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]  IDLE_LAST  = PH_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sck_q, sck_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;

    // State and all pin/result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_conversion) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    ph_d    = '0;
                end
            end

            ST_SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            // Each half-period ends with an sck toggle; miso is taken on the rising toggle
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        shift_d = DATA_WIDTH'({shift_q, bus.miso});
                    end else if (bit_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                        ph_d    = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            // Completion edge: release cs_n and publish the sample together
            ST_HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cs_n_d  = 1'b1;
                    data_d  = shift_q;
                    ready_d = 1'b1;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_GAP: begin
                if (ph_q == IDLE_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cs_n       = cs_n_q;
    assign bus.sck        = sck_q;
    assign bus.adc_data   = data_q;
    assign bus.data_ready = ready_q;
    assign bus.busy       = busy_q;
endmodule
